// File: rtl/dpi_pkg.sv
// Shared types and defaults for the FX3 GPIF-II slave FIFO burst reader.
// Owns the FSM state encoding and the default bus geometry.
package dpi_pkg;

  localparam int DW_DEF      = 32;
  localparam int MAX_WRD_DEF = 8;
  localparam int RD_LAT_DEF  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD    = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/dpi_rd_lat_pipe.sv
// Read-valid shift register matching FX3 read latency.
// Captures the bus word and raises the FIFO write strobe.
module dpi_rd_lat_pipe #(
  parameter int DW     = 32,
  parameter int RD_LAT = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          rd_i,
  input  logic [DW-1:0] dt_i,
  output logic [DW-1:0] dt_o,
  output logic          wr_o,
  output logic          busy_o
);

  logic [RD_LAT-1:0] vld_q;

  // Busy spans the strobe cycle through the write cycle.
  assign busy_o = rd_i | (|vld_q) | wr_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
      dt_o  <= '0;
      wr_o  <= 1'b0;
    end else begin
      vld_q <= (vld_q << 1) | RD_LAT'(rd_i);
      wr_o  <= vld_q[RD_LAT-1];
      if (vld_q[RD_LAT-1]) begin
        dt_o <= dt_i;
      end
    end
  end

endmodule

// File: rtl/dpi_burst_fsm.sv
// FX3 slave FIFO read controller: pulls up to MAX_WRD words
// per start request into the data port FIFO.
module dpi_burst_fsm
  import dpi_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int MAX_WRD = MAX_WRD_DEF,
  parameter int RD_LAT  = RD_LAT_DEF,
  parameter int BURST   = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         strt_i,
  output logic                         done_o,
  input  logic                         FLAG_i,
  output logic                         SLRDn_o,
  input  logic [DW-1:0]                dpi_dt_i,
  output logic [DW-1:0]                dpi_dt_o,
  input  logic                         dpi_full_i,
  input  logic                         dpi_almost_full_i,
  output logic                         dpi_wr_o,
  output logic [$clog2(MAX_WRD+1)-1:0] wrd_cnt_o
);

  localparam int CW = $clog2(MAX_WRD+1);

  state_e        state_q;
  logic [CW-1:0] issued_q;
  logic          busy;
  logic          stop;
  logic          issue;

  assign stop = (issued_q == CW'(MAX_WRD))
              | FLAG_i | dpi_full_i
              | dpi_almost_full_i;

  assign issue = (state_q == RD) & ~stop
               & ((BURST != 0) | ~busy);

  dpi_rd_lat_pipe #(
    .DW     (DW),
    .RD_LAT (RD_LAT)
  ) u_pipe (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .rd_i   (~SLRDn_o),
    .dt_i   (dpi_dt_i),
    .dt_o   (dpi_dt_o),
    .wr_o   (dpi_wr_o),
    .busy_o (busy)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      SLRDn_o   <= 1'b1;
      done_o    <= 1'b0;
      wrd_cnt_o <= '0;
      issued_q  <= '0;
    end else begin
      SLRDn_o <= ~issue;
      done_o  <= 1'b0;
      if (dpi_wr_o) begin
        wrd_cnt_o <= wrd_cnt_o + CW'(1);
      end
      case (state_q)
        IDLE: begin
          // Count restarts with every accepted request.
          if (strt_i) begin
            wrd_cnt_o <= '0;
            issued_q  <= '0;
            if (!FLAG_i && !dpi_full_i) begin
              state_q <= RD;
            end else begin
              state_q <= DONE;
              done_o  <= 1'b1;
            end
          end
        end
        RD: begin
          if (stop) begin
            state_q <= DRAIN;
          end else if (issue) begin
            issued_q <= issued_q + CW'(1);
          end
        end
        DRAIN: begin
          if (!busy) begin
            state_q <= DONE;
            done_o  <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dpi_burst_fsm.sv
// Directed bench for dpi_burst_fsm: burst and single-word modes
// with a scoreboard of expected capture data and write timing.
`timescale 1ns/1ps
module tb_dpi_burst_fsm;

  localparam int LAT = 2;

  typedef struct {
    int          c;
    logic [31:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        strt1 = 1'b0;
  logic        strt2 = 1'b0;
  logic        flag = 1'b0;
  logic        full = 1'b0;
  logic        afull = 1'b0;
  logic [31:0] bus = '0;

  logic        done1, slrd1, wr1o;
  logic [31:0] dt1;
  logic [3:0]  cnt1;
  logic        done2, slrd2, wr2o;
  logic [31:0] dt2;
  logic [2:0]  cnt2;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q1[$];
  exp_t q2[$];
  int   rd1, wr1, run1, maxrun1, dn1;
  int   rd2, wr2, last2;

  always #5 clk = ~clk;

  dpi_burst_fsm u_dut1 (
    .clk_i             (clk),
    .rst_i             (rst),
    .strt_i            (strt1),
    .done_o            (done1),
    .FLAG_i            (flag),
    .SLRDn_o           (slrd1),
    .dpi_dt_i          (bus),
    .dpi_dt_o          (dt1),
    .dpi_full_i        (full),
    .dpi_almost_full_i (afull),
    .dpi_wr_o          (wr1o),
    .wrd_cnt_o         (cnt1)
  );

  dpi_burst_fsm #(
    .MAX_WRD (4),
    .BURST   (0)
  ) u_dut2 (
    .clk_i             (clk),
    .rst_i             (rst),
    .strt_i            (strt2),
    .done_o            (done2),
    .FLAG_i            (flag),
    .SLRDn_o           (slrd2),
    .dpi_dt_i          (bus),
    .dpi_dt_o          (dt2),
    .dpi_full_i        (full),
    .dpi_almost_full_i (afull),
    .dpi_wr_o          (wr2o),
    .wrd_cnt_o         (cnt2)
  );

  function automatic logic [31:0] busv(int t);
    return 32'hC0DE_0000 ^ (t * 32'h0009_E37B);
  endfunction

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // FX3 model: a new word every cycle, a function of cycle number.
  always @(negedge clk) bus = busv(cyc);

  always @(negedge clk) begin
    if (!slrd1) begin
      rd1++;
      run1++;
      if (run1 > maxrun1) maxrun1 = run1;
      q1.push_back('{cyc + LAT + 1, busv(cyc + LAT)});
    end else begin
      run1 = 0;
    end
    if (wr1o) begin
      wr1++;
      chk("wr1_pending", 32'(q1.size() != 0), 1);
      if (q1.size() != 0) begin
        exp_t e;
        e = q1.pop_front();
        chk("wr1_cycle", cyc, e.c);
        chk("wr1_data", dt1, e.d);
      end
    end
    if (done1) dn1++;
  end

  always @(negedge clk) begin
    if (!slrd2) begin
      rd2++;
      if (last2 >= 0) chk("rd2_gap", cyc - last2, 5);
      last2 = cyc;
      q2.push_back('{cyc + LAT + 1, busv(cyc + LAT)});
    end
    if (wr2o) begin
      wr2++;
      chk("wr2_pending", 32'(q2.size() != 0), 1);
      if (q2.size() != 0) begin
        exp_t e;
        e = q2.pop_front();
        chk("wr2_cycle", cyc, e.c);
        chk("wr2_data", dt2, e.d);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic clr1();
    rd1 = 0; wr1 = 0; run1 = 0; maxrun1 = 0; dn1 = 0;
    q1.delete();
  endtask

  task automatic pulse1();
    @(negedge clk) strt1 = 1'b1;
    @(negedge clk) strt1 = 1'b0;
  endtask

  task automatic wait_done1(string tag);
    int k;
    for (k = 0; k < 80; k++) begin
      if (done1) break;
      @(negedge clk);
    end
    chk(tag, done1, 1);
  endtask

  task automatic wait_lows1(int n);
    int seen;
    seen = 0;
    for (int k = 0; k < 40 && seen < n; k++) begin
      @(negedge clk);
      if (!slrd1) seen++;
    end
    chk("lows_reached", seen, n);
  endtask

  initial begin
    rd1 = 0; wr1 = 0; run1 = 0; maxrun1 = 0; dn1 = 0;
    rd2 = 0; wr2 = 0; last2 = -1;
    repeat (3) @(negedge clk);
    chk("rst_slrd", slrd1, 1);
    chk("rst_wr", wr1o, 0);
    chk("rst_done", done1, 0);
    chk("rst_dt", dt1, 0);
    chk("rst_cnt", cnt1, 0);
    chk("rst_cnt2", cnt2, 0);
    rst = 1'b0;
    @(negedge clk);

    // Start with no data available: immediate done, no reads.
    clr1();
    flag = 1'b1;
    strt1 = 1'b1;
    @(negedge clk) strt1 = 1'b0;
    chk("empty_done", done1, 1);
    chk("empty_slrd", slrd1, 1);
    chk("empty_cnt", cnt1, 0);
    @(negedge clk);
    chk("empty_done_1cyc", done1, 0);
    flag = 1'b0;
    repeat (2) @(negedge clk);
    chk("empty_rd", rd1, 0);

    // Full 8-word burst.
    clr1();
    pulse1();
    wait_done1("burst_done");
    chk("burst_cnt", cnt1, 8);
    chk("burst_rd", rd1, 8);
    chk("burst_run", maxrun1, 8);
    chk("burst_wr", wr1, 8);
    @(negedge clk);
    chk("burst_done_1cyc", done1, 0);
    chk("burst_q", q1.size(), 0);
    chk("burst_hold", cnt1, 8);

    // Flag rises after third issue.
    repeat (2) @(negedge clk);
    clr1();
    pulse1();
    wait_lows1(3);
    flag = 1'b1;
    wait_done1("flag_done");
    chk("flag_cnt", cnt1, 3);
    chk("flag_wr", wr1, 3);
    chk("flag_rd", rd1, 3);
    @(negedge clk) flag = 1'b0;

    // Almost-full after fifth issue.
    repeat (2) @(negedge clk);
    clr1();
    pulse1();
    wait_lows1(5);
    afull = 1'b1;
    wait_done1("afull_done");
    chk("afull_cnt", cnt1, 5);
    chk("afull_wr", wr1, 5);
    chk("afull_rd", rd1, 5);
    @(negedge clk) afull = 1'b0;

    // Reset during cycle 4 of a burst.
    repeat (2) @(negedge clk);
    clr1();
    pulse1();
    wait_lows1(3);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_slrd", slrd1, 1);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("midrst_wr", wr1, 0);
    chk("midrst_done", dn1, 0);
    chk("midrst_cnt", cnt1, 0);
    q1.delete();

    // Single-word mode, four words.
    rd2 = 0; wr2 = 0; last2 = -1;
    @(negedge clk) strt2 = 1'b1;
    @(negedge clk) strt2 = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (done2) break;
      @(negedge clk);
    end
    chk("single_done", done2, 1);
    chk("single_cnt", cnt2, 4);
    chk("single_rd", rd2, 4);
    chk("single_wr", wr2, 4);
    chk("single_q", q2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
